// File: rtl/ipu_kernel_loader.sv
`default_nettype none
// ============================================================================
//  Module   : ipu_kernel_loader
//  Purpose  : Takes one decoded filter descriptor (size, opcode, packed
//             kernel) and issues it to the convolution coprocessor. The
//             coefficients are written one element per handshake into the
//             coefficient memory, and then the operation command is issued.
//  Revision : 1.0 - initial release
// ============================================================================
module ipu_kernel_loader #(
    parameter int ELEM_W    = 8,
    parameter int MAX_ELEMS = 25
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [1:0]                    size,
    input  logic [3:0]                    opcode,
    input  logic [ELEM_W*MAX_ELEMS-1:0]   kernel,
    output logic                          wr_en,
    output logic [$clog2(MAX_ELEMS)-1:0]  wr_addr,
    output logic [ELEM_W-1:0]             wr_data,
    input  logic                          wr_ready,
    output logic                          cmd_valid,
    output logic [3:0]                    cmd_opcode,
    output logic [1:0]                    cmd_size,
    input  logic                          cmd_ready,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    localparam int KW = ELEM_W * MAX_ELEMS;
    localparam int AW = $clog2(MAX_ELEMS);

    // The short (3x5) kernel occupies only the low bytes of the packed word.
    localparam int              c_SHORT_ELEMS = 15;
    localparam int              c_PAD_BITS    = (MAX_ELEMS - c_SHORT_ELEMS) * ELEM_W;
    localparam logic [AW-1:0]   c_LAST_SHORT  = AW'(c_SHORT_ELEMS - 1);
    localparam logic [AW-1:0]   c_LAST_LONG   = AW'(MAX_ELEMS - 1);

    localparam logic [3:0]      c_OP_CONV      = 4'b0101;
    localparam logic [3:0]      c_OP_CONV_TRSP = 4'b0110;
    localparam logic [3:0]      c_OP_CONV_ROB  = 4'b0111;
    localparam logic [3:0]      c_OP_B2G       = 4'b1000;

    localparam logic [1:0]      c_IDLE = 2'd0;
    localparam logic [1:0]      c_LOAD = 2'd1;
    localparam logic [1:0]      c_CMD  = 2'd2;
    localparam logic [1:0]      c_FIN  = 2'd3;

    logic [1:0]         r_state;
    logic [KW-1:0]      r_shift;
    logic [AW-1:0]      r_last;
    logic [AW-1:0]      r_addr;
    logic [ELEM_W-1:0]  r_data;
    logic               r_wr_en;
    logic               r_cmd_valid;
    logic [3:0]         r_opcode;
    logic [1:0]         r_size;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic               w_op_valid;
    logic [KW-1:0]      w_norm;
    logic [AW-1:0]      w_last;

    // Decode the incoming descriptor; a short kernel is left-aligned so
    // element 0 always sits in the top byte of the shift register.
    always_comb begin
        w_op_valid = (opcode == c_OP_CONV) || (opcode == c_OP_CONV_TRSP) ||
                     (opcode == c_OP_CONV_ROB) || (opcode == c_OP_B2G);
        w_norm     = size[1] ? kernel : (kernel << c_PAD_BITS);
        w_last     = size[1] ? c_LAST_LONG : c_LAST_SHORT;
    end

    // Control FSM: latch descriptor, stream coefficients, issue command, pulse done.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_shift     <= '0;
            r_last      <= '0;
            r_addr      <= '0;
            r_data      <= '0;
            r_wr_en     <= 1'b0;
            r_cmd_valid <= 1'b0;
            r_opcode    <= '0;
            r_size      <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_opcode <= opcode;
                        r_size   <= size;
                        r_last   <= w_last;
                        r_addr   <= '0;
                        r_data   <= w_norm[KW-1 -: ELEM_W];
                        r_shift  <= w_norm << ELEM_W;
                        if (!w_op_valid) begin
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= c_FIN;
                        end else if (opcode == c_OP_B2G) begin
                            r_cmd_valid <= 1'b1;
                            r_busy      <= 1'b1;
                            r_state     <= c_CMD;
                        end else begin
                            r_wr_en <= 1'b1;
                            r_busy  <= 1'b1;
                            r_state <= c_LOAD;
                        end
                    end
                end
                c_LOAD: begin
                    // Address and data only move on an accepted write.
                    if (r_wr_en && wr_ready) begin
                        if (r_addr == r_last) begin
                            r_wr_en     <= 1'b0;
                            r_cmd_valid <= 1'b1;
                            r_state     <= c_CMD;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_data  <= r_shift[KW-1 -: ELEM_W];
                            r_shift <= r_shift << ELEM_W;
                        end
                    end
                end
                c_CMD: begin
                    if (cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= c_FIN;
                    end
                end
                c_FIN: begin
                    r_done  <= 1'b0;
                    r_err   <= 1'b0;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign wr_en      = r_wr_en;
    assign wr_addr    = r_addr;
    assign wr_data    = r_data;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_opcode = r_opcode;
    assign cmd_size   = r_size;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ipu_kernel_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ipu_kernel_loader
//  Purpose  : Scoreboard bench for ipu_kernel_loader. A descriptor-level
//             model queues the expected writes, command and completion; a
//             monitor pops and compares whenever the DUT hands something off.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ipu_kernel_loader;

    localparam int ELEM_W    = 8;
    localparam int MAX_ELEMS = 25;
    localparam int KW        = ELEM_W * MAX_ELEMS;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    size = '0;
    logic [3:0]    opcode = '0;
    logic [KW-1:0] kernel = '0;
    logic          wr_ready = 1'b1;
    logic          cmd_ready = 1'b1;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [7:0]    wr_data;
    logic          cmd_valid;
    logic [3:0]    cmd_opcode;
    logic [1:0]    cmd_size;
    logic          busy;
    logic          done;
    logic          err;

    ipu_kernel_loader #(.ELEM_W(ELEM_W), .MAX_ELEMS(MAX_ELEMS)) dut (
        .clk(clk), .reset(reset), .start(start), .size(size), .opcode(opcode),
        .kernel(kernel), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready), .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode),
        .cmd_size(cmd_size), .cmd_ready(cmd_ready), .busy(busy), .done(done),
        .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard queues ----------------
    logic [4:0] q_addr[$];
    logic [7:0] q_data[$];
    logic [5:0] q_cmd[$];
    logic       q_err[$];

    function automatic bit op_valid(input logic [3:0] op);
        return (op == 4'h5) || (op == 4'h6) || (op == 4'h7) || (op == 4'h8);
    endfunction

    function automatic bit op_loads(input logic [3:0] op);
        return (op == 4'h5) || (op == 4'h6) || (op == 4'h7);
    endfunction

    // Descriptor-level model: element i is byte (N-1-i) of the packed kernel.
    task automatic push_model(input logic [1:0] s, input logic [3:0] op, input logic [KW-1:0] k);
        int n;
        n = s[1] ? 25 : 15;
        if (op_loads(op)) begin
            for (int i = 0; i < n; i++) begin
                q_addr.push_back(5'(i));
                q_data.push_back(k[8*(n-1-i) +: 8]);
            end
        end
        if (op_valid(op)) q_cmd.push_back({op, s});
        q_err.push_back(!op_valid(op));
    endtask

    function automatic logic [KW-1:0] rand_kernel();
        logic [KW-1:0] k;
        k = '0;
        for (int i = 0; i < 7; i++) k = {k[KW-33:0], 32'($urandom)};
        return k;
    endfunction

    // ---------------- ready driver ----------------
    int mode = 0;
    int cmd_hold = 0;
    always @(posedge clk) begin
        #1;
        if (mode == 1) begin
            wr_ready = ~wr_ready;
            if (cmd_valid) begin
                cmd_ready = (cmd_hold >= 3);
                cmd_hold++;
            end else begin
                cmd_ready = 1'b0;
                cmd_hold  = 0;
            end
        end else begin
            wr_ready  = 1'b1;
            cmd_ready = 1'b1;
            cmd_hold  = 0;
        end
    end

    // ---------------- monitor ----------------
    int         wr_cnt = 0;
    int         stalls = 0;
    int         cmd_len = 0;
    int         done_cnt = 0;
    int         done_cyc = -1;
    int         wr_first = -1;
    int         cmd_first = -1;
    logic [7:0] obs_data[25];
    logic       p_stall = 1'b0;
    logic [4:0] p_addr = '0;
    logic [7:0] p_data = '0;
    logic       p_done = 1'b0;

    always @(negedge clk) begin
        if (p_stall) check("stall_hold", {wr_en, wr_addr, wr_data}, {1'b1, p_addr, p_data});
        if (wr_en) begin
            check("busy_during_wr", busy, 1);
            if (wr_first < 0) wr_first = cyc;
        end
        if (wr_en && wr_ready) begin
            wr_cnt++;
            if (wr_addr < 25) obs_data[wr_addr] = wr_data;
            if (q_addr.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_wr: got addr %0d data %0h, expected no write", wr_addr, wr_data);
            end else begin
                check("wr_addr", wr_addr, q_addr.pop_front());
                check("wr_data", wr_data, q_data.pop_front());
            end
        end
        if (wr_en && !wr_ready) stalls++;
        p_stall = wr_en && !wr_ready;
        p_addr  = wr_addr;
        p_data  = wr_data;
        if (cmd_valid) begin
            cmd_len++;
            if (cmd_first < 0) cmd_first = cyc;
        end
        if (cmd_valid && cmd_ready) begin
            if (q_cmd.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_cmd: got %0h, expected no command", {cmd_opcode, cmd_size});
            end else begin
                check("cmd_op_size", {cmd_opcode, cmd_size}, q_cmd.pop_front());
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            check("done_single_pulse", p_done, 0);
            check("busy_at_done", busy, 0);
            if (q_err.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_done: got done err=%0b, expected no done", err);
            end else begin
                check("err", err, q_err.pop_front());
            end
        end else if (err) begin
            n_checks++; n_fail++;
            $display("FAIL err_without_done: got err=1, expected 0");
        end
        p_done = done;
    end

    // ---------------- stimulus ----------------
    task automatic clear_obs();
        for (int i = 0; i < 25; i++) obs_data[i] = 8'h5A;
    endtask

    task automatic run(input logic [1:0] s, input logic [3:0] op, input logic [KW-1:0] k,
                       input int md, input bit poke, output int t0);
        int dc0, n, w, exp_cmd, done_rel;
        bit ld, vl;
        mode = md;
        @(posedge clk); #1;
        push_model(s, op, k);
        wr_first = -1; cmd_first = -1; cmd_len = 0; stalls = 0; wr_cnt = 0;
        dc0 = done_cnt;
        size = s; opcode = op; kernel = k; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        size = 2'($urandom); opcode = 4'($urandom); kernel = rand_kernel();
        if (poke) begin
            repeat (4) @(posedge clk);
            #1 start = 1'b1;
            opcode = 4'h6;
            @(posedge clk);
            #1 start = 1'b0;
        end
        w = 0;
        while (done_cnt == dc0 && w < 400) begin
            @(negedge clk);
            w++;
        end
        check("done_seen", done_cnt - dc0, 1);
        n  = s[1] ? 25 : 15;
        ld = op_loads(op);
        vl = op_valid(op);
        exp_cmd  = vl ? ((md == 1) ? 4 : 1) : 0;
        done_rel = done_cyc - t0 + 1;
        check("cmd_len", cmd_len, exp_cmd);
        check("wr_count", wr_cnt, ld ? n : 0);
        check("done_latency", done_rel, (ld ? n : 0) + stalls + exp_cmd + 1);
        if (ld) check("first_wr_cycle", wr_first - t0 + 1, 1);
        if (vl && md == 0) check("cmd_cycle", cmd_first - t0 + 1, (ld ? n : 0) + 1);
        check("queues_empty", q_addr.size() + q_cmd.size() + q_err.size(), 0);
    endtask

    initial begin
        int t0, dc0;
        logic [KW-1:0] sob, lap, kr;
        logic [1:0] s;
        logic [3:0] op;
        int r;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {wr_en, wr_addr, wr_data, cmd_valid, cmd_opcode, cmd_size, busy, done, err}, 0);
        @(posedge clk); #1 reset = 1'b0;

        // Sobel 3x5, upper bytes random and must be ignored
        sob = rand_kernel();
        sob[119:0] = 120'h000001_00FF00_000200_FE0000_0100FF;
        clear_obs();
        run(2'b01, 4'b0110, sob, 0, 1'b0, t0);
        check("sobel_a0", obs_data[0], 8'h00);
        check("sobel_a2", obs_data[2], 8'h01);
        check("sobel_a4", obs_data[4], 8'hFF);
        check("sobel_a7", obs_data[7], 8'h02);
        check("sobel_a9", obs_data[9], 8'hFE);
        check("sobel_a14", obs_data[14], 8'hFF);
        check("sobel_done_cycle", done_cyc - t0 + 1, 17);

        // B2G immediately afterwards (start in the cycle after done)
        run(2'b00, 4'b1000, '0, 0, 1'b0, t0);
        check("b2g_done_cycle", done_cyc - t0 + 1, 2);

        // Invalid opcode
        run(2'b10, 4'b0000, rand_kernel(), 0, 1'b0, t0);
        check("inv_done_cycle", done_cyc - t0 + 1, 1);

        // Laplace 5x5
        lap = '0;
        lap[8*12 +: 8] = 8'h10;
        lap[8*17 +: 8] = 8'hFC;
        lap[8*13 +: 8] = 8'hFC;
        lap[8*11 +: 8] = 8'hFC;
        lap[8*7  +: 8] = 8'hFC;
        clear_obs();
        run(2'b11, 4'b0101, lap, 0, 1'b0, t0);
        check("lap_a12", obs_data[12], 8'h10);
        check("lap_a0", obs_data[0], 8'h00);
        check("lap_done_cycle", done_cyc - t0 + 1, 27);

        // Backpressure with an ignored start while busy
        run(2'b11, 4'b0111, rand_kernel(), 1, 1'b1, t0);
        dc0 = done_cnt;
        r = wr_cnt;
        repeat (30) @(negedge clk);
        check("poke_no_done", done_cnt - dc0, 0);
        check("poke_no_wr", wr_cnt - r, 0);

        // Reset mid-transfer
        mode = 0;
        @(posedge clk); #1;
        push_model(2'b11, 4'b0101, lap);
        dc0 = done_cnt;
        size = 2'b11; opcode = 4'b0101; kernel = lap; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q_addr.delete(); q_data.delete(); q_cmd.delete(); q_err.delete();
        wr_cnt = 0; cmd_len = 0;
        @(negedge clk);
        check("midrst_outputs", {wr_en, wr_addr, wr_data, cmd_valid, cmd_opcode, cmd_size, busy, done, err}, 0);
        repeat (40) @(negedge clk);
        check("midrst_no_done", done_cnt - dc0, 0);
        check("midrst_no_wr", wr_cnt, 0);
        check("midrst_no_cmd", cmd_len, 0);
        run(2'b10, 4'b0110, rand_kernel(), 0, 1'b0, t0);

        // Random descriptors, random backpressure
        for (int i = 0; i < 12; i++) begin
            r  = $urandom_range(0, 9);
            op = (r < 8) ? 4'(5 + (r % 4)) : 4'($urandom_range(0, 15));
            s  = 2'($urandom);
            kr = rand_kernel();
            run(s, op, kr, $urandom_range(0, 1), 1'b0, t0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/ipu_kernel_loader.md
# ipu_kernel_loader

Consumes one decoded filter descriptor (size, opcode, 200-bit kernel) and issues it to the convolution coprocessor. The kernel is serialized into the coprocessor's coefficient memory one 8-bit element per handshake, then the matching operation command is issued. Sits between the filter-code decoder and the IPU datapath. It is the sequential consumer of the decoder's packed kernel format.

## Interface
Parameters:
- ELEM_W, 8, coefficient width in bits (signed two's complement, passed through unmodified)
- MAX_ELEMS, 25, coefficient memory depth (5x5)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous active-high reset
- start  in  1  one-cycle request to load a descriptor; sampled only in IDLE
- size  in  2  kernel size code: 00 or 01 selects 15 elements; 10 or 11 selects 25 elements
- opcode  in  4  0101 CONV, 0110 CONV_TRSP, 0111 CONV_ROB, 1000 B2G; all other values are invalid
- kernel  in  200  packed coefficients, first element in the most significant byte
- wr_en  out  1  coefficient write valid
- wr_addr  out  5  coefficient index 0..24, row-major
- wr_data  out  8  coefficient value
- wr_ready  in  1  memory accepts the write this cycle
- cmd_valid  out  1  command valid
- cmd_opcode  out  4  latched opcode
- cmd_size  out  2  latched size
- cmd_ready  in  1  coprocessor accepts the command
- busy  out  1  high in LOAD and CMD
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse, coincident with done, for an invalid opcode

## Operation
- States are IDLE, LOAD, CMD, and FIN.
- IDLE: when start=1, latch size, opcode, and kernel, and clear the element counter.
  - A valid opcode other than B2G goes to LOAD.
  - B2G goes directly to CMD; no writes are issued.
  - An invalid opcode goes to FIN with the error flag set.
- Element count N is 15 when size[1]=0 and 25 when size[1]=1.
- Element i (0..N-1) is taken from kernel bits [8*(N-1-i)+7 : 8*(N-1-i)].
  - N=15 uses bits [119:0] only; bits [199:120] are ignored.
- LOAD: drive wr_en=1, wr_addr=i, wr_data=element i.
  - A transfer occurs when wr_en and wr_ready are both high; the counter then increments.
  - While wr_ready=0, address and data are held stable.
  - After the transfer of element N-1, the next state is CMD.
- CMD: cmd_valid=1 with the latched opcode and size, held stable until cmd_ready=1, then go to FIN.
- FIN: done=1, and err=1 if the opcode was invalid. Next state is IDLE.
- start outside IDLE is ignored; the latched descriptor is not modified.
- Input changes after the start cycle have no effect on the transfer in progress.

## Timing
- Reset values: state IDLE, and wr_en, wr_addr, wr_data, cmd_valid, cmd_opcode, cmd_size, busy, done, err all 0.
- Reset asserted mid-transfer aborts the transfer. From the next edge, no further wr_en or cmd_valid is driven and no done pulse is produced.
- All outputs are registered.
- Start is sampled at edge 0. wr_en is first high in cycle 1, addr 0.
- With wr_ready and cmd_ready tied high:
  - N=15: writes occur in cycles 1..15, cmd_valid in cycle 16, done in cycle 17. The next start is accepted in cycle 18.
  - N=25: done in cycle 27.
  - B2G: cmd_valid in cycle 1, done in cycle 2.
  - Invalid opcode: done and err in cycle 1.
- Each cycle of wr_ready=0 or cmd_ready=0 adds exactly one cycle of latency.
- busy=1 exactly while in LOAD or CMD.
- done and err are never high for more than one cycle.

## Test plan
- Sobel descriptor (size 01, opcode 0110, low bytes ...01,00,FF), ready signals tied high.
  - Expect 15 writes: addr 0 data 00, addr 2 data 01, addr 4 data FF, addr 7 data 02, addr 9 data FE, addr 14 data FF.
  - Then cmd 0110/01 in cycle 16 and done in cycle 17.
- Laplace descriptor (size 11, opcode 0101).
  - Expect 25 writes with addr 12 data 10 and addr 0 data 00, and done in cycle 27.
- B2G (opcode 1000, kernel 0).
  - Expect no wr_en, cmd_valid in cycle 1, done in cycle 2.
- Opcode 0000.
  - Expect done=err=1 in cycle 1, with no wr_en and no cmd_valid.
- Backpressure: wr_ready toggles 1/0 and cmd_ready is held 0 for 3 cycles.
  - Expect addr/data stable while stalled and no skipped or duplicate addresses.
  - Expect cmd_valid held for 4 cycles.
  - Expect a second start during busy to be ignored.
- Reset mid-transfer: assert reset in cycle 6.
  - Expect all outputs 0 from cycle 7 and no done.
  - A new start afterwards must begin again at addr 0.
